wash_sequencer: RTL and testbench

- Parametrised washing-machine program sequencer. Successor to the fixed wash/water/dewater controller-plus-timer pair.
- Runs a multi-cycle programme: fill, wash, drain, N rinse cycles, spin, done.
- Adds pause/resume, a fill-timeout fault and a BCD countdown of the current phase.
- Uses an internal clock-enable tick instead of divided clocks. Drives valves, motor and buzzer, and feeds the existing dynamic-scan and segment-decode blocks.

---
 rtl/wash_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Washing-machine programme sequencer: fill, wash, drain, N rinse cycles,
// spin, done, with pause/resume, fill-timeout alarm and a BCD countdown.
module wash_sequencer #(
  parameter int unsigned TICK_DIV     = 24000000,
  parameter int unsigned WASH_T       = 30,
  parameter int unsigned RINSE_T      = 20,
  parameter int unsigned DRAIN_T      = 10,
  parameter int unsigned SPIN_T       = 20,
  parameter int unsigned FILL_MAX     = 60,
  parameter int unsigned DONE_T       = 5,
  parameter int unsigned RINSE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       waterfull,
  output logic       valve_in,
  output logic       valve_out,
  output logic       motor_wash,
  output logic       motor_spin,
  output logic       buzzer,
  output logic       fault,
  output logic [2:0] state_out,
  output logic [2:0] cycle_idx,
  output logic [3:0] seg3,
  output logic [3:0] seg2,
  output logic [3:0] seg1,
  output logic [3:0] seg0
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5,
    S_PAUSE = 3'd6,
    S_ALARM = 3'd7
  } state_t;

  localparam int unsigned   PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  function automatic logic [15:0] to_bcd(input int unsigned v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Remaining time is kept directly in BCD so the display digits need no
  // binary-to-decimal conversion; this is a 4-digit borrow-chain decrement.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic       borrow;
    logic [3:0] d;
    bcd_dec = v;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      bcd_dec[4*i +: 4] = d;
    end
  endfunction

  localparam logic [15:0] BCD_FILL  = to_bcd(FILL_MAX);
  localparam logic [15:0] BCD_WASH  = to_bcd(WASH_T);
  localparam logic [15:0] BCD_RINSE = to_bcd(RINSE_T);
  localparam logic [15:0] BCD_DRAIN = to_bcd(DRAIN_T);
  localparam logic [15:0] BCD_SPIN  = to_bcd(SPIN_T);
  localparam logic [15:0] BCD_DONE  = to_bcd(DONE_T);

  state_t        state_q, state_d, resume_q, resume_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   rem_q, rem_d;
  logic [2:0]    cyc_q, cyc_d;
  logic [5:0]    outs_q, outs_d;
  logic          tick, expire, enter, clear;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    presc_d  = presc_q;
    rem_d    = rem_q;
    cyc_d    = cyc_q;
    enter    = 1'b0;
    clear    = 1'b0;
    tick     = (presc_q == PMAX);
    expire   = tick && (rem_q == 16'h0001);

    if ((state_q inside {S_FILL, S_WASH, S_DRAIN, S_SPIN, S_DONE}) && !stop) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick && !expire) rem_d = bcd_dec(rem_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_FILL;
          cyc_d   = '0;
          enter   = 1'b1;
        end
      end
      S_FILL: begin
        if (stop) begin
          state_d  = S_PAUSE;
          resume_d = state_q;
        end else if (waterfull) begin
          state_d = S_WASH;
          enter   = 1'b1;
        end else if (expire) begin
          state_d = S_ALARM;
        end
      end
      S_WASH: begin
        if (stop) begin
          state_d  = S_PAUSE;
          resume_d = state_q;
        end else if (expire) begin
          state_d = S_DRAIN;
          enter   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (stop) begin
          state_d  = S_PAUSE;
          resume_d = state_q;
        end else if (expire) begin
          enter = 1'b1;
          if (int'(cyc_q) < int'(RINSE_CYCLES)) begin
            cyc_d   = cyc_q + 3'd1;
            state_d = S_FILL;
          end else begin
            state_d = S_SPIN;
          end
        end
      end
      S_SPIN: begin
        if (stop) begin
          state_d  = S_PAUSE;
          resume_d = state_q;
        end else if (expire) begin
          state_d = S_DONE;
          enter   = 1'b1;
        end
      end
      S_DONE: begin
        if (stop || expire) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end else if (start) begin
          state_d = resume_q;
        end
      end
      S_ALARM: begin
        if (stop) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        clear   = 1'b1;
      end
    endcase

    if (enter) begin
      presc_d = '0;
      case (state_d)
        S_FILL:  rem_d = BCD_FILL;
        S_WASH:  rem_d = (cyc_d == 3'd0) ? BCD_WASH : BCD_RINSE;
        S_DRAIN: rem_d = BCD_DRAIN;
        S_SPIN:  rem_d = BCD_SPIN;
        S_DONE:  rem_d = BCD_DONE;
        default: rem_d = rem_q;
      endcase
    end

    if (clear) begin
      presc_d = '0;
      rem_d   = '0;
      cyc_d   = '0;
    end

    // {valve_in, valve_out, motor_wash, motor_spin, buzzer, fault}
    outs_d = {state_d == S_FILL,
              (state_d == S_DRAIN) || (state_d == S_SPIN),
              state_d == S_WASH,
              state_d == S_SPIN,
              state_d == S_DONE,
              state_d == S_ALARM};
  end

  // State, counters and actuator outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      resume_q <= S_IDLE;
      presc_q  <= '0;
      rem_q    <= '0;
      cyc_q    <= '0;
      outs_q   <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      presc_q  <= presc_d;
      rem_q    <= rem_d;
      cyc_q    <= cyc_d;
      outs_q   <= outs_d;
    end
  end

  assign {valve_in, valve_out, motor_wash, motor_spin, buzzer, fault} = outs_q;
  assign state_out = state_q;
  assign cycle_idx = cyc_q;
  assign {seg3, seg2, seg1, seg0} = rem_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with a small tick divider.
module tb_wash_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, waterfull;
  logic       valve_in, valve_out, motor_wash, motor_spin, buzzer, fault;
  logic [2:0] state_out, cycle_idx;
  logic [3:0] seg3, seg2, seg1, seg0;

  int total = 0;
  int bad   = 0;

  wash_sequencer #(
    .TICK_DIV(4), .WASH_T(3), .RINSE_T(2), .DRAIN_T(2), .SPIN_T(3),
    .FILL_MAX(5), .DONE_T(2), .RINSE_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .waterfull(waterfull),
    .valve_in(valve_in), .valve_out(valve_out), .motor_wash(motor_wash),
    .motor_spin(motor_spin), .buzzer(buzzer), .fault(fault),
    .state_out(state_out), .cycle_idx(cycle_idx),
    .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0)
  );

  always #5 clk = ~clk;

  // {valve_in, valve_out, motor_wash, motor_spin, buzzer, fault}
  function automatic logic [5:0] outs();
    return {valve_in, valve_out, motor_wash, motor_spin, buzzer, fault};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; waterfull = 1'b0;
    step(3);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_outs", 32'(outs()), 32'h00);
    chk("rst_seg", 32'({seg3, seg2, seg1, seg0}), 32'h0000);
    chk("rst_cyc", 32'(cycle_idx), 32'd0);
    reset = 1'b1;
    step(2);

    // Full programme with one rinse cycle
    pulse_start();
    chk("fill_state", 32'(state_out), 32'd1);
    chk("fill_outs", 32'(outs()), 32'h20);
    chk("fill_seg", 32'(seg0), 32'd5);
    chk("fill_cyc", 32'(cycle_idx), 32'd0);
    step(2);
    waterfull = 1'b1;
    step(1);
    waterfull = 1'b0;
    chk("wash_state", 32'(state_out), 32'd2);
    chk("wash_outs", 32'(outs()), 32'h08);
    chk("wash_seg3", 32'(seg0), 32'd3);
    step(4);
    chk("wash_seg2", 32'(seg0), 32'd2);
    step(4);
    chk("wash_seg1", 32'(seg0), 32'd1);
    step(3);
    chk("wash_11", 32'(state_out), 32'd2);
    step(1);
    chk("drain_state", 32'(state_out), 32'd3);
    chk("drain_outs", 32'(outs()), 32'h10);
    chk("drain_seg", 32'(seg0), 32'd2);
    step(7);
    chk("drain_7", 32'(state_out), 32'd3);
    step(1);
    chk("fill2_state", 32'(state_out), 32'd1);
    chk("fill2_cyc", 32'(cycle_idx), 32'd1);
    chk("fill2_seg", 32'(seg0), 32'd5);
    waterfull = 1'b1;
    step(1);
    waterfull = 1'b0;
    chk("rinse_state", 32'(state_out), 32'd2);
    chk("rinse_seg", 32'(seg0), 32'd2);
    step(7);
    chk("rinse_7", 32'(state_out), 32'd2);
    step(1);
    chk("drain2_state", 32'(state_out), 32'd3);
    step(8);
    chk("spin_state", 32'(state_out), 32'd4);
    chk("spin_outs", 32'(outs()), 32'h14);
    chk("spin_seg", 32'(seg0), 32'd3);
    step(11);
    chk("spin_11", 32'(state_out), 32'd4);
    step(1);
    chk("done_state", 32'(state_out), 32'd5);
    chk("done_outs", 32'(outs()), 32'h02);
    chk("done_seg", 32'(seg0), 32'd2);
    step(7);
    chk("done_7", 32'(state_out), 32'd5);
    step(1);
    chk("end_state", 32'(state_out), 32'd0);
    chk("end_outs", 32'(outs()), 32'h00);
    chk("end_seg", 32'({seg3, seg2, seg1, seg0}), 32'h0000);
    chk("end_cyc", 32'(cycle_idx), 32'd0);

    // Fill timeout
    pulse_start();
    step(19);
    chk("to_19", 32'(state_out), 32'd1);
    chk("to_seg", 32'(seg0), 32'd1);
    step(1);
    chk("alarm_state", 32'(state_out), 32'd7);
    chk("alarm_outs", 32'(outs()), 32'h01);
    pulse_start();
    chk("alarm_start_ign", 32'(state_out), 32'd7);
    pulse_stop();
    chk("alarm_clr_state", 32'(state_out), 32'd0);
    chk("alarm_clr_outs", 32'(outs()), 32'h00);

    // Pause / resume in WASH
    pulse_start();
    waterfull = 1'b1;
    step(1);
    waterfull = 1'b0;
    step(4);
    chk("pre_pause_seg", 32'(seg0), 32'd2);
    pulse_stop();
    chk("pause_state", 32'(state_out), 32'd6);
    chk("pause_outs", 32'(outs()), 32'h00);
    step(100);
    chk("pause_hold_state", 32'(state_out), 32'd6);
    chk("pause_hold_seg", 32'(seg0), 32'd2);
    pulse_start();
    chk("resume_state", 32'(state_out), 32'd2);
    chk("resume_outs", 32'(outs()), 32'h08);
    chk("resume_seg", 32'(seg0), 32'd2);
    step(7);
    chk("resume_7", 32'(state_out), 32'd2);
    chk("resume_7_seg", 32'(seg0), 32'd1);
    step(1);
    chk("resume_drain", 32'(state_out), 32'd3);

    // Abort from DRAIN via pause
    pulse_stop();
    chk("abort_pause", 32'(state_out), 32'd6);
    chk("abort_pause_seg", 32'(seg0), 32'd2);
    pulse_stop();
    chk("abort_state", 32'(state_out), 32'd0);
    chk("abort_seg", 32'({seg3, seg2, seg1, seg0}), 32'h0000);
    chk("abort_cyc", 32'(cycle_idx), 32'd0);

    // start and stop together in WASH: stop wins
    pulse_start();
    waterfull = 1'b1;
    step(1);
    waterfull = 1'b0;
    chk("ss_wash", 32'(state_out), 32'd2);
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("ss_pause", 32'(state_out), 32'd6);
    pulse_stop();
    chk("ss_idle", 32'(state_out), 32'd0);

    // waterfull arriving on the timeout tick wins over ALARM
    pulse_start();
    step(19);
    chk("wf_to_seg", 32'(seg0), 32'd1);
    waterfull = 1'b1;
    step(1);
    waterfull = 1'b0;
    chk("wf_to_wash", 32'(state_out), 32'd2);
    chk("wf_to_outs", 32'(outs()), 32'h08);

    // Run on to SPIN, then reset asynchronously between edges
    step(12);
    chk("r_drain", 32'(state_out), 32'd3);
    step(8);
    chk("r_fill", 32'(state_out), 32'd1);
    waterfull = 1'b1;
    step(1);
    waterfull = 1'b0;
    step(8);
    chk("r_drain2", 32'(state_out), 32'd3);
    step(8);
    chk("r_spin", 32'(state_out), 32'd4);
    step(5);
    chk("r_spin_outs", 32'(outs()), 32'h14);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_state", 32'(state_out), 32'd0);
    chk("arst_outs", 32'(outs()), 32'h00);
    chk("arst_seg", 32'({seg3, seg2, seg1, seg0}), 32'h0000);
    step(2);
    reset = 1'b1;
    step(1);
    pulse_start();
    chk("post_rst_state", 32'(state_out), 32'd1);
    chk("post_rst_cyc", 32'(cycle_idx), 32'd0);
    chk("post_rst_outs", 32'(outs()), 32'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
